piece_drop_ctrl: RTL and testbench
==================================

PIECE_DROP_CTRL -- requirements
Module: piece_drop_ctrl

Interface
REQ-001 Parameter: FALL_CYCLES, default 4, clocks per row step of the animated fall (used only with DROP_ANIM_EN).
REQ-002 clk  in  1  single system clock, rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 new_game  in  1  synchronous clear of board, heights, turn and FSM.
REQ-005 col_valid  in  1  move request qualifier.
REQ-006 col_idx  in  3  column 0..6 from the column decoder; 7 is illegal.
REQ-007 busy  out  1  high whenever FSM is not IDLE.
REQ-008 cur_player  out  1  player to move: 0 red, 1 yellow.
REQ-009 board_red  out  42  red occupancy, bit = row*7+col, row 0 = bottom.
REQ-010 board_yellow  out  42  yellow occupancy, same indexing.
REQ-011 drop_done  out  1  one-cycle pulse when a piece is committed.
REQ-012 drop_row  out  3  row of the last committed piece.
REQ-013 drop_col  out  3  column of the last committed piece.
REQ-014 invalid_move  out  1  one-cycle pulse for a rejected request.
REQ-015 board_full  out  1  all seven columns hold 6 pieces.
REQ-016 fall_active  out  1  animated piece in flight.
REQ-017 fall_row  out  3  current row of animated piece.

Function
REQ-018 Storage: seven 3-bit column heights (0..6), two 42-bit occupancy registers, latched column.
REQ-019 FSM states: IDLE, CHECK, FALL (macro only), COMMIT.
REQ-020 IDLE: col_valid=1 at edge k -> latch col_idx, go CHECK; col_valid while busy is ignored, not queued.
REQ-021 CHECK (edge k+1): col_idx=7 or height[col]=6 -> invalid_move=1 for one cycle, go IDLE, no state change otherwise.
REQ-022 CHECK legal -> COMMIT (or FALL with macro).
REQ-023 COMMIT edge: set bit height*7+col in board of cur_player, height+1, drop_row=old height, drop_col=col, drop_done=1 one cycle, toggle cur_player, go IDLE.
REQ-024 Latency without macro: drop_done high in cycle after edge k+2; invalid_move high in cycle after edge k+1.
REQ-025 board_red AND board_yellow SHALL always be zero.
REQ-026 board_full combinational from heights; request while full -> invalid_move.
REQ-027 new_game has priority over any state and col_valid: next edge clears boards, heights, pulses, cur_player=0, state IDLE.
REQ-028 drop_row/drop_col hold last value until next commit.

Reset
REQ-029 rst_n low: state IDLE, boards 0, heights 0, cur_player 0, drop_done 0, invalid_move 0, drop_row 0, drop_col 0, fall_active 0, fall_row 0, counters 0.
REQ-030 Reset mid-move abandons the move; no partial board write.

Configuration
REQ-031 Macro DROP_ANIM_EN defined: CHECK legal -> FALL with fall_row=5, fall_active=1; each FALL_CYCLES clocks fall_row decrements; when fall_row equals height[col] and count expires, go COMMIT, fall_active=0.
REQ-032 Macro undefined: no FALL state, fall_active and fall_row tied 0, latency per REQ-024.
REQ-033 new_game or reset during FALL clears fall_active immediately per REQ-027/029.

Verification
REQ-034 Reset, col_idx=3 valid one cycle -> drop_done after 2 edges, board_red bit 3, drop_row=0, cur_player=1.
REQ-035 Seven drops into column 0 -> drops 1..6 commit rows 0..5 alternating colours; seventh -> invalid_move, boards unchanged, cur_player unchanged.
REQ-036 col_idx=7 -> invalid_move one cycle, no board change.
REQ-037 col_valid held high 5 cycles, col 2 -> exactly one commit per IDLE pass, busy high in CHECK/COMMIT.
REQ-038 Fill all 42 cells -> board_full=1, further request -> invalid_move; new_game -> all cleared, board_full=0.
REQ-039 DROP_ANIM_EN, FALL_CYCLES=4, empty column 5 -> fall_row 5..0, drop_done after 2+24 edges; rst_n low mid-fall -> all outputs reset.

Source files
------------

// File: rtl/piece_drop_ctrl_if.sv
// Move request/response bundle for piece_drop_ctrl.
//   col_valid, col_idx        : move request (column 0..6, 7 is illegal)
//   busy                      : controller is processing a move
//   drop_done, drop_row/col   : commit pulse and position of the last placed piece
//   invalid_move              : rejection pulse
// master = requester side, slave = controller side.
interface piece_drop_ctrl_if;
  logic       col_valid;
  logic [2:0] col_idx;
  logic       busy;
  logic       drop_done;
  logic       invalid_move;
  logic [2:0] drop_row;
  logic [2:0] drop_col;

  modport master (
    output col_valid, col_idx,
    input  busy, drop_done, invalid_move, drop_row, drop_col
  );

  modport slave (
    input  col_valid, col_idx,
    output busy, drop_done, invalid_move, drop_row, drop_col
  );
endinterface

// File: rtl/piece_drop_ctrl.sv
// Connect-four piece drop controller: accepts a column request, validates it
// against the column heights, optionally animates the falling piece, then
// commits it into the current player's occupancy board and hands the turn over.
//
// Optional feature: define DROP_ANIM_EN to add the animated FALL state
// (one row step every FALL_CYCLES clocks). Without it fall_active/fall_row are 0.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   new_game       : synchronous clear of board, heights, turn and FSM
//   mv (slave)     : move request/response bundle (see piece_drop_ctrl_if)
//   cur_player     : player to move, 0 red / 1 yellow
//   board_red      : red occupancy, bit = row*7+col, row 0 = bottom
//   board_yellow   : yellow occupancy, same indexing
//   board_full     : every column holds 6 pieces (decoded from heights)
//   fall_active    : animated piece in flight
//   fall_row       : current row of the animated piece
module piece_drop_ctrl #(
  parameter int unsigned FALL_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_game,
  piece_drop_ctrl_if.slave    mv,
  output logic                cur_player,
  output logic [41:0]         board_red,
  output logic [41:0]         board_yellow,
  output logic                board_full,
  output logic                fall_active,
  output logic [2:0]          fall_row
);

  localparam int unsigned COLS  = 7;
  localparam int unsigned ROWS  = 6;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned IDX_W = 6;
  localparam logic [2:0]  BAD_COL = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    FALL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                  state_q, state_nxt;
  logic [2:0]              col_q, col_nxt;
  logic [COLS-1:0][2:0]    heights_q, heights_nxt;
  logic [CELLS-1:0]        red_q, red_nxt;
  logic [CELLS-1:0]        yel_q, yel_nxt;
  logic                    player_q, player_nxt;
  logic                    done_q, done_nxt;
  logic                    inval_q, inval_nxt;
  logic [2:0]              row_q, row_nxt;
  logic [2:0]              dcol_q, dcol_nxt;

  // Height of the latched column and the board cell it addresses
  logic [2:0]              cur_h;
  logic [IDX_W-1:0]        bit_idx;
  logic [CELLS-1:0]        cell_mask;

`ifdef DROP_ANIM_EN
  localparam int unsigned CNT_W = (FALL_CYCLES > 1) ? $clog2(FALL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FALL_CYCLES - 1);

  logic                    fa_q, fa_nxt;
  logic [2:0]              fr_q, fr_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_nxt;
`else
  // FALL_CYCLES only shapes the animation; a zero value is never meaningful
  if (FALL_CYCLES == 0) begin : g_zero_fall_cycles
  end
`endif

  // Height lookup for the latched column (7 reads as an empty column)
  always_comb begin
    cur_h = '0;
    for (int i = 0; i < int'(COLS); i++) begin
      if (col_q == 3'(i)) cur_h = heights_q[i];
    end
    bit_idx   = IDX_W'(cur_h) * IDX_W'(COLS) + IDX_W'(col_q);
    cell_mask = CELLS'(1) << bit_idx;
  end

  // Board full when no column has room left
  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < int'(COLS); i++) begin
      if (heights_q[i] != 3'(ROWS)) board_full = 1'b0;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt   = state_q;
    col_nxt     = col_q;
    heights_nxt = heights_q;
    red_nxt     = red_q;
    yel_nxt     = yel_q;
    player_nxt  = player_q;
    done_nxt    = 1'b0;
    inval_nxt   = 1'b0;
    row_nxt     = row_q;
    dcol_nxt    = dcol_q;
`ifdef DROP_ANIM_EN
    fa_nxt      = fa_q;
    fr_nxt      = fr_q;
    cnt_nxt     = cnt_q;
`endif

    if (new_game) begin
      state_nxt   = IDLE;
      col_nxt     = '0;
      heights_nxt = '0;
      red_nxt     = '0;
      yel_nxt     = '0;
      player_nxt  = 1'b0;
      row_nxt     = '0;
      dcol_nxt    = '0;
`ifdef DROP_ANIM_EN
      fa_nxt      = 1'b0;
      fr_nxt      = '0;
      cnt_nxt     = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mv.col_valid) begin
            col_nxt   = mv.col_idx;
            state_nxt = CHECK;
          end
        end

        CHECK: begin
          if (col_q == BAD_COL || cur_h == 3'(ROWS)) begin
            inval_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
`ifdef DROP_ANIM_EN
            // Piece enters at the top row and steps down to its landing row
            state_nxt = FALL;
            fa_nxt    = 1'b1;
            fr_nxt    = 3'(ROWS - 1);
            cnt_nxt   = '0;
`else
            state_nxt = COMMIT;
`endif
          end
        end

`ifdef DROP_ANIM_EN
        FALL: begin
          if (cnt_q == CNT_LAST) begin
            cnt_nxt = '0;
            if (fr_q == cur_h) begin
              fa_nxt    = 1'b0;
              state_nxt = COMMIT;
            end else begin
              fr_nxt = fr_q - 3'd1;
            end
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
`endif

        COMMIT: begin
          if (player_q) yel_nxt = yel_q | cell_mask;
          else          red_nxt = red_q | cell_mask;
          for (int i = 0; i < int'(COLS); i++) begin
            if (col_q == 3'(i)) heights_nxt[i] = cur_h + 3'd1;
          end
          done_nxt   = 1'b1;
          row_nxt    = cur_h;
          dcol_nxt   = col_q;
          player_nxt = ~player_q;
          state_nxt  = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      heights_q <= '0;
      red_q     <= '0;
      yel_q     <= '0;
      player_q  <= 1'b0;
      done_q    <= 1'b0;
      inval_q   <= 1'b0;
      row_q     <= '0;
      dcol_q    <= '0;
`ifdef DROP_ANIM_EN
      fa_q      <= 1'b0;
      fr_q      <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_nxt;
      col_q     <= col_nxt;
      heights_q <= heights_nxt;
      red_q     <= red_nxt;
      yel_q     <= yel_nxt;
      player_q  <= player_nxt;
      done_q    <= done_nxt;
      inval_q   <= inval_nxt;
      row_q     <= row_nxt;
      dcol_q    <= dcol_nxt;
`ifdef DROP_ANIM_EN
      fa_q      <= fa_nxt;
      fr_q      <= fr_nxt;
      cnt_q     <= cnt_nxt;
`endif
    end
  end

  assign mv.busy         = (state_q != IDLE);
  assign mv.drop_done    = done_q;
  assign mv.invalid_move = inval_q;
  assign mv.drop_row     = row_q;
  assign mv.drop_col     = dcol_q;
  assign cur_player      = player_q;
  assign board_red       = red_q;
  assign board_yellow    = yel_q;

`ifdef DROP_ANIM_EN
  assign fall_active = fa_q;
  assign fall_row    = fr_q;
`else
  assign fall_active = 1'b0;
  assign fall_row    = '0;
`endif

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Scoreboard bench for piece_drop_ctrl: the driver pushes the reference
// model's expected response per request; a negedge monitor pops and compares
// whenever the controller reports a commit or a rejection.
module tb_piece_drop_ctrl;

  localparam int unsigned FALL_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        cur_player;
  logic [41:0] board_red;
  logic [41:0] board_yellow;
  logic        board_full;
  logic        fall_active;
  logic [2:0]  fall_row;

  piece_drop_ctrl_if mv_if ();

  piece_drop_ctrl #(.FALL_CYCLES(FALL_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_game     (new_game),
    .mv           (mv_if),
    .cur_player   (cur_player),
    .board_red    (board_red),
    .board_yellow (board_yellow),
    .board_full   (board_full),
    .fall_active  (fall_active),
    .fall_row     (fall_row)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        inval;
    int          cyc;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [41:0] red;
    logic [41:0] yel;
    logic        player;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;

  // Reference model: grid[col][row] = 0 empty, 1 red, 2 yellow
  int         grid [7][6];
  int         player;
  logic [2:0] last_row, last_col;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) grid[c][r] = 0;
    player   = 0;
    last_row = '0;
    last_col = '0;
  endfunction

  function automatic int model_h(input int c);
    int h = 0;
    for (int r = 0; r < 6; r++) if (grid[c][r] != 0) h++;
    return h;
  endfunction

  function automatic logic model_full();
    for (int c = 0; c < 7; c++) if (model_h(c) != 6) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_cells();
    int n = 0;
    for (int c = 0; c < 7; c++) n += model_h(c);
    return n;
  endfunction

  // Apply one request issued when cyc == issue_cyc; return the expected response
  function automatic exp_t model_apply(input logic [2:0] c, input int issue_cyc);
    exp_t e;
    int   ci = int'(c);
    int   h  = (ci == 7) ? 0 : model_h(ci);
    if (ci == 7 || h == 6) begin
      e.inval = 1'b1;
      e.cyc   = issue_cyc + 2;
    end else begin
      e.inval = 1'b0;
`ifdef DROP_ANIM_EN
      e.cyc   = issue_cyc + 3 + (6 - h) * int'(FALL_CYCLES);
`else
      e.cyc   = issue_cyc + 3;
`endif
      grid[ci][h] = player + 1;
      player      = 1 - player;
      last_row    = 3'(h);
      last_col    = c;
    end
    e.row = last_row;
    e.col = last_col;
    e.red = '0;
    e.yel = '0;
    for (int cc = 0; cc < 7; cc++)
      for (int r = 0; r < 6; r++) begin
        if (grid[cc][r] == 1) e.red[r*7+cc] = 1'b1;
        if (grid[cc][r] == 2) e.yel[r*7+cc] = 1'b1;
      end
    e.player = (player != 0);
    return e;
  endfunction

  // Monitor: compare each reported event against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (mv_if.drop_done || mv_if.invalid_move)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b invalid=%0b, expected no event (cycle %0d)",
                 mv_if.drop_done, mv_if.invalid_move, cyc);
      end else begin
        me = exp_q.pop_front();
        chk("event_kind", 64'({mv_if.drop_done, mv_if.invalid_move}), me.inval ? 64'd1 : 64'd2);
        chk("event_cycle", 64'(cyc), 64'(me.cyc));
        chk("drop_row", 64'(mv_if.drop_row), 64'(me.row));
        chk("drop_col", 64'(mv_if.drop_col), 64'(me.col));
        chk("board_red", 64'(board_red), 64'(me.red));
        chk("board_yellow", 64'(board_yellow), 64'(me.yel));
        chk("cur_player", 64'(cur_player), 64'(me.player));
        chk("board_overlap", 64'(board_red & board_yellow), 64'd0);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL response_timeout: %0d responses pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_red"}, 64'(board_red), 64'd0);
    chk({tag, "_yellow"}, 64'(board_yellow), 64'd0);
    chk({tag, "_player"}, 64'(cur_player), 64'd0);
    chk({tag, "_busy"}, 64'(mv_if.busy), 64'd0);
    chk({tag, "_full"}, 64'(board_full), 64'd0);
    chk({tag, "_done"}, 64'(mv_if.drop_done), 64'd0);
    chk({tag, "_invalid"}, 64'(mv_if.invalid_move), 64'd0);
    chk({tag, "_drop_row"}, 64'(mv_if.drop_row), 64'd0);
    chk({tag, "_drop_col"}, 64'(mv_if.drop_col), 64'd0);
    chk({tag, "_fall_active"}, 64'(fall_active), 64'd0);
    chk({tag, "_fall_row"}, 64'(fall_row), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mv_if.col_valid = 1'b0;
    new_game = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    model_clear();
  endtask

  task automatic start_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_clear();
    chk_clear("new_game");
  endtask

  // One request pulse; called at posedge+1
  task automatic move(input logic [2:0] c);
    exp_q.push_back(model_apply(c, cyc));
    mv_if.col_valid = 1'b1;
    mv_if.col_idx   = c;
    @(posedge clk); #1;
    mv_if.col_valid = 1'b0;
    mv_if.col_idx   = 3'($urandom);
    chk("busy_after_accept", 64'(mv_if.busy), 64'd1);
    wait_drain();
    chk("busy_idle", 64'(mv_if.busy), 64'd0);
    chk("board_full", 64'(board_full), 64'(model_full()));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] busy_pat;
    int         guard;
    logic [2:0] rc;

    mv_if.col_valid = 1'b0;
    mv_if.col_idx   = '0;
    do_reset();
    chk_clear("reset");

    // First drop in the middle column
    move(3'd3);

    // Seven drops into column 0: six commits, then a rejection
    start_game();
    for (int i = 0; i < 7; i++) move(3'd0);

    // Illegal column index
    move(3'd7);

    // Request held high for five edges: only IDLE passes accept
    start_game();
    exp_q.push_back(model_apply(3'd2, cyc));
`ifdef DROP_ANIM_EN
    busy_pat = 5'b11111;
`else
    exp_q.push_back(model_apply(3'd2, cyc + 3));
    busy_pat = 5'b11011;
`endif
    mv_if.col_valid = 1'b1;
    mv_if.col_idx   = 3'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_busy", 64'(mv_if.busy), 64'(busy_pat[i]));
    end
    mv_if.col_valid = 1'b0;
    wait_drain();

    // new_game beats a simultaneous request
    mv_if.col_valid = 1'b1;
    mv_if.col_idx   = 3'd4;
    start_game();
    mv_if.col_valid = 1'b0;

    // new_game in the middle of a move abandons it
    mv_if.col_valid = 1'b1;
    mv_if.col_idx   = 3'd4;
    @(posedge clk); #1;
    mv_if.col_valid = 1'b0;
    start_game();
    repeat (40) @(posedge clk);
    #1;
    chk("abort_red", 64'(board_red), 64'd0);

    // Fill the whole board in random column order
    start_game();
    guard = 0;
    while (model_cells() < 42 && guard < 2000) begin
      rc = 3'($urandom_range(0, 6));
      if (model_h(int'(rc)) < 6) move(rc);
      guard++;
    end
    chk("full_after_fill", 64'(board_full), 64'd1);
    move(3'($urandom_range(0, 7)));
    start_game();

    // Random play including illegal and full columns
    start_game();
    for (int i = 0; i < 60; i++) move(3'($urandom_range(0, 7)));

`ifdef DROP_ANIM_EN
    // Animated fall into an empty column
    do_reset();
    exp_q.push_back(model_apply(3'd5, cyc));
    mv_if.col_valid = 1'b1;
    mv_if.col_idx   = 3'd5;
    @(posedge clk); #1;
    mv_if.col_valid = 1'b0;
    @(posedge clk);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      chk("fall_active", 64'(fall_active), 64'd1);
      chk("fall_row", 64'(fall_row), 64'(5 - j / 4));
    end
    wait_drain();
    chk("fall_active_end", 64'(fall_active), 64'd0);
`endif

    // Asynchronous reset in the middle of a move
    mv_if.col_valid = 1'b1;
    mv_if.col_idx   = 3'd5;
    @(posedge clk); #1;
    mv_if.col_valid = 1'b0;
`ifdef DROP_ANIM_EN
    repeat (6) @(posedge clk);
    #1;
    chk("mid_fall_active", 64'(fall_active), 64'd1);
`else
    @(posedge clk); #1;
`endif
    rst_n = 1'b0;
    #1;
    chk_clear("reset_mid_move");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    repeat (30) @(posedge clk);
    #1;
    chk("post_reset_red", 64'(board_red), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
